// File: rtl/g16_rr_arbiter_if.sv
// g16 arbiter bus bundle: master request/grant side plus the slave transfer side.
//
// Handshake: a master raises need[i] (a level) and holds it until it sees
// Clast_mstr[i]. YouGotIt[i] is the grant. While tarActive is high the slave
// owns the transfer. Clast is the slave's last-beat flag and only counts while
// tarActive is high; it reaches the granted master as Clast_mstr. Dropping
// need before Clast is an abort.
interface g16_rr_arbiter_if #(
  parameter int NUM_MSTR = 4,
  parameter int ADDR_W   = 48,
  parameter int DATA_W   = 16
);
  logic [NUM_MSTR-1:0]        need;
  logic [NUM_MSTR*ADDR_W-1:0] addrM;
  logic [NUM_MSTR*DATA_W-1:0] DoutM;
  logic [NUM_MSTR-1:0]        YouGotIt;
  logic [DATA_W-1:0]          DinMast;
  logic [NUM_MSTR-1:0]        Clast_mstr;
  logic [ADDR_W-1:0]          Adr;
  logic [DATA_W-1:0]          dbus_in;
  logic                       tarActive;
  logic [DATA_W-1:0]          dataOut;
  logic                       Clast;
  logic                       abort_err;
  logic                       tmo_err;

  // Arbiter side: it drives grants and the slave bus.
  modport master (
    input  need, addrM, DoutM, dataOut, Clast,
    output YouGotIt, DinMast, Clast_mstr, Adr, dbus_in, tarActive, abort_err, tmo_err
  );

  // Environment side: the masters and the slave.
  modport slave (
    output need, addrM, DoutM, dataOut, Clast,
    input  YouGotIt, DinMast, Clast_mstr, Adr, dbus_in, tarActive, abort_err, tmo_err
  );
endinterface

// File: rtl/g16_rr_arbiter.sv
// Round-robin arbiter and bus switch for the 16-bit g16 bus.
// FSM IDLE -> GRANT -> XFER -> RELEASE. Output registers are loaded from the
// next-state decode, so the outputs line up with the state they belong to.
module g16_rr_arbiter #(
  parameter int NUM_MSTR = 4,
  parameter int ADDR_W   = 48,
  parameter int DATA_W   = 16,
  parameter int TIMEOUT  = 256
) (
  input  logic                 sysClk,
  input  logic                 rst,
  g16_rr_arbiter_if.master     bus,
  output logic [1:0]           state_dbg
);

  localparam int PTR_W  = $clog2(NUM_MSTR);
  localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit WDOG_EN = (TIMEOUT > 0);
  localparam logic [WDOG_W-1:0] WDOG_LAST = (TIMEOUT > 0) ? WDOG_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_XFER    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    win_q, win_d;
  logic [PTR_W-1:0]    win_next;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                found;
  logic [PTR_W-1:0]    pick;
  logic                abort_d, tmo_d;
  logic                tmo_hit;
  logic [NUM_MSTR-1:0] gnt_q, gnt_d;
  logic                tar_q, tar_d;
  logic [ADDR_W-1:0]   adr_q, adr_sel;
  logic [DATA_W-1:0]   dbus_q, dbus_sel;
  logic                abort_q, tmo_q;
  logic                own_bus;

  assign state_dbg = state_q;

  // Rotating priority search: first requester at or after ptr, wrapping.
  always_comb begin
    logic [PTR_W:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_MSTR; k++) begin
      idx = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(NUM_MSTR)) idx = idx - (PTR_W+1)'(NUM_MSTR);
      if (!found && bus.need[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[PTR_W-1:0];
      end
    end
  end

  assign win_next = (win_q == PTR_W'(NUM_MSTR - 1)) ? '0 : win_q + 1'b1;
  assign tmo_hit  = WDOG_EN && (wdog_q == WDOG_LAST);

  // Next-state logic; exit priority in XFER is Clast, then abort, then timeout.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    abort_d = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d   = pick;
          state_d = S_GRANT;
        end
      end
      S_GRANT: state_d = S_XFER;
      S_XFER: begin
        if (bus.Clast) begin
          ptr_d   = win_next;
          state_d = S_RELEASE;
        end else if (!bus.need[win_q]) begin
          abort_d = 1'b1;
          ptr_d   = win_next;
          state_d = S_RELEASE;
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          ptr_d   = win_next;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode for the next cycle: grant, transfer flag, mux of the winner's bus.
  always_comb begin
    own_bus  = (state_d == S_GRANT) || (state_d == S_XFER);
    gnt_d    = '0;
    if (own_bus) gnt_d[win_d] = 1'b1;
    tar_d    = (state_d == S_XFER);
    adr_sel  = '0;
    dbus_sel = '0;
    for (int m = 0; m < NUM_MSTR; m++) begin
      if (win_d == PTR_W'(m)) begin
        adr_sel  = bus.addrM[m*ADDR_W +: ADDR_W];
        dbus_sel = bus.DoutM[m*DATA_W +: DATA_W];
      end
    end
    wdog_d = '0;
    if (WDOG_EN && state_q == S_XFER && state_d == S_XFER) wdog_d = wdog_q + 1'b1;
  end

  // State, pointer, watchdog and registered outputs; reset clears all at once.
  always_ff @(posedge sysClk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      wdog_q  <= '0;
      gnt_q   <= '0;
      tar_q   <= 1'b0;
      adr_q   <= '0;
      dbus_q  <= '0;
      abort_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      wdog_q  <= wdog_d;
      gnt_q   <= gnt_d;
      tar_q   <= tar_d;
      abort_q <= abort_d;
      tmo_q   <= tmo_d;
      // Address/data hold their last value when no master owns the bus.
      if (own_bus) begin
        adr_q  <= adr_sel;
        dbus_q <= dbus_sel;
      end
    end
  end

  assign bus.YouGotIt   = gnt_q;
  assign bus.tarActive  = tar_q;
  assign bus.Adr        = adr_q;
  assign bus.dbus_in    = dbus_q;
  assign bus.abort_err  = abort_q;
  assign bus.tmo_err    = tmo_q;
  assign bus.DinMast    = bus.dataOut;
  // Clast only reaches the granted master while a transfer is active.
  assign bus.Clast_mstr = {NUM_MSTR{bus.Clast & tar_q}} & gnt_q;

endmodule

// File: tb/tb_g16_rr_arbiter.sv
// Bench for g16_rr_arbiter: grant order scoreboard plus directed burst checks.
module tb_g16_rr_arbiter;
  localparam int NM = 4;
  localparam int AW = 48;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  g16_rr_arbiter_if #(.NUM_MSTR(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();
  g16_rr_arbiter_if #(.NUM_MSTR(NM), .ADDR_W(AW), .DATA_W(DW)) bus0 ();
  logic [1:0] state_dbg, state_dbg0;

  g16_rr_arbiter #(.NUM_MSTR(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) u_dut (
    .sysClk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );
  g16_rr_arbiter #(.NUM_MSTR(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(0)) u_dut0 (
    .sysClk(clk), .rst(rst), .bus(bus0), .state_dbg(state_dbg0)
  );

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;
  logic [NM-1:0] exp_q[$];
  logic [NM-1:0] prev_gnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard: grant order and one-hot grant ----------------
  always @(negedge clk) begin
    check_eq("onehot", 64'($onehot0(bus.YouGotIt)), 64'd1);
    if (bus.YouGotIt != '0 && prev_gnt == '0) begin
      if (exp_q.size() == 0) check_eq("grant_unexpected", 64'(bus.YouGotIt), 64'd0);
      else                   check_eq("grant_order", 64'(bus.YouGotIt), 64'(exp_q.pop_front()));
    end
    prev_gnt <= bus.YouGotIt;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.need  = '0;
    bus.Clast = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_tar(input string tag, output int at_cyc);
    int n = 0;
    while (!bus.tarActive && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_wait_tar"}, 64'(bus.tarActive), 64'd1);
    at_cyc = cyc;
  endtask

  // Slave model: B beats, Clast and rdata on the last one, Clast held one extra cycle.
  task automatic run_burst(input string tag, input int beats, input logic [DW-1:0] rdata,
                           input logic [NM-1:0] gnt, output int t0);
    wait_tar(tag, t0);
    check_eq({tag, "_gnt"}, 64'(bus.YouGotIt), 64'(gnt));
    for (int b = 1; b <= beats; b++) begin
      if (b == beats) begin
        bus.Clast   = 1'b1;
        bus.dataOut = rdata;
        #1;
        check_eq({tag, "_dinmast"}, 64'(bus.DinMast), 64'(rdata));
        check_eq({tag, "_clast_mstr"}, 64'(bus.Clast_mstr), 64'(gnt));
      end else begin
        bus.Clast   = 1'b0;
        bus.dataOut = DW'($urandom_range(0, 65535));
        #1;
        check_eq({tag, "_clast_mstr_mid"}, 64'(bus.Clast_mstr), 64'd0);
      end
      tick();
    end
    check_eq({tag, "_rel_gnt"}, 64'(bus.YouGotIt), 64'd0);
    check_eq({tag, "_rel_clast_mstr"}, 64'(bus.Clast_mstr), 64'd0);
    check_eq({tag, "_rel_tar"}, 64'(bus.tarActive), 64'd0);
    bus.Clast = 1'b0;
  endtask

  // ---------------- global time bound ----------------
  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "time bound exceeded");
  end

  // ---------------- main sequence ----------------
  initial begin
    int t0;
    int ts[5];
    int n;
    int tmo_cnt;
    bus.need = '0;  bus.addrM = '0;  bus.DoutM = '0;  bus.dataOut = '0;  bus.Clast = 1'b0;
    bus0.need = '0; bus0.addrM = '0; bus0.DoutM = '0; bus0.dataOut = '0; bus0.Clast = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    tick();
    rst = 1'b0;

    // reset state
    check_eq("rst_gnt",   64'(bus.YouGotIt),  64'd0);
    check_eq("rst_tar",   64'(bus.tarActive), 64'd0);
    check_eq("rst_adr",   64'(bus.Adr),       64'd0);
    check_eq("rst_dbus",  64'(bus.dbus_in),   64'd0);
    check_eq("rst_abort", 64'(bus.abort_err), 64'd0);
    check_eq("rst_tmo",   64'(bus.tmo_err),   64'd0);
    check_eq("rst_state", 64'(state_dbg),     64'd0);

    // 1: single request from master 2; c0 is this cycle
    bus.addrM[2*AW +: AW] = 48'h0000_1234_5678;
    bus.DoutM[2*DW +: DW] = 16'hA5A5;
    bus.need = 4'b0100;
    exp_q.push_back(4'b0100);
    tick();                                   // c1
    tick();                                   // c2
    check_eq("t1_gnt_c2", 64'(bus.YouGotIt), 64'h4);
    tick();                                   // c3
    check_eq("t1_tar_c3", 64'(bus.tarActive), 64'd1);
    check_eq("t1_adr_c3", 64'(bus.Adr), 64'h0000_1234_5678);
    check_eq("t1_dbus_c3", 64'(bus.dbus_in), 64'hA5A5);
    bus.addrM[2*AW +: AW] = 48'h0000_0000_ABCD;
    #1;
    check_eq("t1_adr_hold", 64'(bus.Adr), 64'h0000_1234_5678);
    tick();                                   // c4
    check_eq("t1_adr_reload", 64'(bus.Adr), 64'h0000_0000_ABCD);
    run_burst("t1", 1, 16'h1111, 4'b0100, t0);
    bus.need = '0;
    tick();
    check_eq("t1_adr_idle_hold", 64'(bus.Adr), 64'h0000_0000_ABCD);

    // 2: all four request, two-beat bursts, strict rotation from ptr 0
    do_reset();
    for (int i = 0; i < NM; i++) begin
      bus.addrM[i*AW +: AW] = AW'($urandom_range(0, 32'h7fff_ffff));
      bus.DoutM[i*DW +: DW] = DW'($urandom_range(0, 65535));
    end
    bus.need = 4'b1111;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    for (int i = 0; i < 5; i++) begin
      logic [NM-1:0] g;
      g = '0;
      g[i % NM] = 1'b1;
      run_burst("t2", 2, DW'($urandom_range(0, 65535)), g, ts[i]);
    end
    bus.need = '0;
    for (int i = 1; i < 5; i++) check_eq("t2_period", 64'(ts[i] - ts[i-1]), 64'd5);

    // 3: master 1, three beats, read data returned with Clast on the 3rd beat
    bus.need = 4'b0010;
    exp_q.push_back(4'b0010);
    run_burst("t3", 3, 16'hBEEF, 4'b0010, t0);
    bus.need = '0;

    // 4: master 3 drops need on its 2nd XFER cycle; master 0 waiting
    bus.need = 4'b1000;
    exp_q.push_back(4'b1000);
    wait_tar("t4", t0);
    tick();
    bus.need = 4'b0001;
    exp_q.push_back(4'b0001);
    #1;
    check_eq("t4_abort_early", 64'(bus.abort_err), 64'd0);
    tick();
    check_eq("t4_abort_pulse", 64'(bus.abort_err), 64'd1);
    check_eq("t4_tmo_quiet", 64'(bus.tmo_err), 64'd0);
    check_eq("t4_clast_mstr", 64'(bus.Clast_mstr), 64'd0);
    check_eq("t4_tar_drop", 64'(bus.tarActive), 64'd0);
    tick();
    check_eq("t4_abort_single", 64'(bus.abort_err), 64'd0);
    run_burst("t4b", 1, 16'h0F0F, 4'b0001, t0);
    bus.need = '0;

    // 5: slave never ends the burst; watchdog (TIMEOUT=8) releases it
    bus.need = 4'b0100;
    exp_q.push_back(4'b0100);
    wait_tar("t5", t0);
    n = 0;
    while (bus.tarActive && n < 40) begin
      n++;
      tick();
    end
    check_eq("t5_xfer_cycles", 64'(n), 64'd8);
    check_eq("t5_tmo_pulse", 64'(bus.tmo_err), 64'd1);
    check_eq("t5_abort_quiet", 64'(bus.abort_err), 64'd0);
    check_eq("t5_gnt_drop", 64'(bus.YouGotIt), 64'd0);
    bus.need = '0;
    tick();
    check_eq("t5_tmo_single", 64'(bus.tmo_err), 64'd0);

    // 6: reset mid-transfer of master 2, then master 1 wins from ptr 0
    do_reset();
    bus.need = 4'b0010;
    exp_q.push_back(4'b0010);
    run_burst("t6a", 1, 16'h2222, 4'b0010, t0);
    bus.need = '0;
    tick();
    bus.need = 4'b0110;
    exp_q.push_back(4'b0100);
    wait_tar("t6", t0);
    tick();
    bus.Clast = 1'b1;
    #1;
    check_eq("t6_pre_clast_mstr", 64'(bus.Clast_mstr), 64'h4);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_rst_gnt", 64'(bus.YouGotIt), 64'd0);
    check_eq("t6_rst_tar", 64'(bus.tarActive), 64'd0);
    check_eq("t6_rst_clast_mstr", 64'(bus.Clast_mstr), 64'd0);
    check_eq("t6_rst_adr", 64'(bus.Adr), 64'd0);
    check_eq("t6_rst_state", 64'(state_dbg), 64'd0);
    bus.Clast = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.push_back(4'b0010);
    run_burst("t6b", 1, 16'h3333, 4'b0010, t0);
    bus.need = '0;
    tick();

    // 5b: watchdog disabled, transfer left open for 1000 cycles
    bus0.need = 4'b0001;
    tmo_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (bus0.tmo_err) tmo_cnt++;
    end
    check_eq("t5b_no_tmo", 64'(tmo_cnt), 64'd0);
    check_eq("t5b_still_active", 64'(bus0.tarActive), 64'd1);
    check_eq("t5b_still_gnt", 64'(bus0.YouGotIt), 64'h1);
    bus0.need = '0;
    tick();

    check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
